// File: rtl/i2s_rx_deser.sv
// I2S receiver: synchronises sclk/lrclk/sdata into aud_mclk, frames MSB-first words and buffers them for AXI-Stream.
// Optional I2S_RX_SWAP_CHAN_EN inverts the channel tag for boards with swapped left/right wiring.
module i2s_rx_deser #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        aud_mclk,
    input  logic        aud_mrst_n,
    input  logic        rx_en,
    input  logic        sclk_in,
    input  logic        lrclk_in,
    input  logic        sdata_0_in,
    output logic [31:0] m_axis_tdata,
    output logic [2:0]  m_axis_tid,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] fifo_rdata_count,
    output logic        frame_err,
    output logic        irq,
    input  logic        irq_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] ST_SEEK  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [5:0] LAST_BIT = 6'(DATA_WIDTH - 1);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [1:0] sclk_sync, lr_sync, sd_sync;
    logic       sclk_q, sclk_s, lr_s, sd_s, sclk_rise;
    logic       lr_prev, lr_edge;
    logic [1:0] state;
    logic [5:0] cnt;
    logic       ch;
    logic [DATA_WIDTH-2:0] sreg;
    logic       push;
    logic [DATA_WIDTH:0] push_data;

    always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
        if (!aud_mrst_n) begin
            sclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            sclk_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk_in};
            lr_sync   <= {lr_sync[0], lrclk_in};
            sd_sync   <= {sd_sync[0], sdata_0_in};
            sclk_q    <= sclk_sync[1];
        end
    end

    assign sclk_s    = sclk_sync[1];
    assign lr_s      = lr_sync[1];
    assign sd_s      = sd_sync[1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign lr_edge   = lr_s ^ lr_prev;

    // The last bit goes straight into the FIFO on its own rise so the word is readable one cycle later.
    assign push      = rx_en & sclk_rise & (state == ST_SHIFT) & ~lr_edge & (cnt == LAST_BIT);
    assign push_data = {ch, sreg, sd_s};

    always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
        if (!aud_mrst_n) begin
            state     <= ST_SEEK;
            cnt       <= '0;
            ch        <= 1'b0;
            sreg      <= '0;
            lr_prev   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (sclk_rise) lr_prev <= lr_s;
            if (!rx_en) begin
                state <= ST_SEEK;
            end else if (sclk_rise) begin
                case (state)
                    ST_SEEK, ST_WAIT: begin
                        if (lr_edge) begin
                            cnt   <= '0;
                            ch    <= lr_s;
                            state <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (lr_edge) begin
                            frame_err <= 1'b1;
                            cnt       <= '0;
                            ch        <= lr_s;
                        end else begin
                            sreg <= {sreg[DATA_WIDTH-3:0], sd_s};
                            cnt  <= cnt + 6'd1;
                            if (cnt == LAST_BIT) state <= ST_WAIT;
                        end
                    end
                    default: state <= ST_SEEK;
                endcase
            end
        end
    end

    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic        empty, full, pop, wr_ok, overflow;
    logic [DATA_WIDTH:0] head;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = ~empty & m_axis_tready;
    assign wr_ok    = push & (~full | pop);
    assign overflow = push & full & ~pop;
    assign head     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aud_mclk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
        if (!aud_mrst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_ok, pop})
                2'b10:   count <= count + PTR_ONE;
                2'b01:   count <= count - PTR_ONE;
                default: count <= count;
            endcase
            // Overflow set takes priority over a simultaneous clear.
            if (overflow)     irq <= 1'b1;
            else if (irq_clr) irq <= 1'b0;
        end
    end

    assign m_axis_tvalid    = ~empty;
    assign m_axis_tdata     = empty ? 32'd0 : (32'(head[DATA_WIDTH-1:0]) << (32 - DATA_WIDTH));
    assign fifo_rdata_count = 16'(count);
`ifdef I2S_RX_SWAP_CHAN_EN
    assign m_axis_tid = {2'b00, ~head[DATA_WIDTH] & ~empty};
`else
    assign m_axis_tid = {2'b00, head[DATA_WIDTH] & ~empty};
`endif

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Directed bench for i2s_rx_deser: framing, truncation, overflow, backpressure, reset and enable.
module tb_i2s_rx_deser;
  logic        aud_mclk = 1'b0;
  logic        aud_mrst_n = 1'b0;
  logic        rx_en = 1'b0;
  logic        sclk_in = 1'b0;
  logic        lrclk_in = 1'b0;
  logic        sdata_0_in = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [2:0]  m_axis_tid;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [15:0] fifo_rdata_count;
  logic        frame_err;
  logic        irq;
  logic        irq_clr = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  logic [34:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [34:0] prev_beat = '0;
  logic        bp_done = 1'b0;

  i2s_rx_deser #(.DATA_WIDTH(24), .FIFO_DEPTH(4)) dut (
    .aud_mclk(aud_mclk),
    .aud_mrst_n(aud_mrst_n),
    .rx_en(rx_en),
    .sclk_in(sclk_in),
    .lrclk_in(lrclk_in),
    .sdata_0_in(sdata_0_in),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tid(m_axis_tid),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .fifo_rdata_count(fifo_rdata_count),
    .frame_err(frame_err),
    .irq(irq),
    .irq_clr(irq_clr)
  );

  // clock / reset
  always #5 aud_mclk = ~aud_mclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted beat must match the head of exp_q; stalled heads must hold
  always begin
    @(negedge aud_mclk);
    #1;
    if (!aud_mrst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_err) fe_cnt++;
      if (prev_stall) begin
        check("stall_valid", 64'(m_axis_tvalid), 64'd1);
        check("stall_data", 64'({m_axis_tid, m_axis_tdata}), 64'(prev_beat));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("beat", 64'({m_axis_tid, m_axis_tdata}), 64'(exp_q.pop_front()));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tid, m_axis_tdata};
    end
  end

  // driver tasks: data changes with sclk falling, 8 mclk per bit
  task automatic sclk_cycle(input logic lr, input logic d);
    @(negedge aud_mclk);
    sclk_in = 1'b0;
    lrclk_in = lr;
    sdata_0_in = d;
    repeat (3) @(negedge aud_mclk);
    sclk_in = 1'b1;
    repeat (4) @(negedge aud_mclk);
  endtask

  // 32-bit slot: delay bit, 24 data bits MSB first, then padding
  task automatic send_slot(input logic lr, input logic [23:0] w);
    for (int i = 0; i < 32; i++) begin
      if (i >= 1 && i <= 24) sclk_cycle(lr, w[24-i]);
      else sclk_cycle(lr, 1'b1);
    end
  endtask

  task automatic settle;
    @(negedge aud_mclk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && !m_axis_tvalid) break;
      settle();
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge aud_mclk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_tid", 64'(m_axis_tid), 64'd0);
    check("rst_count", 64'(fifo_rdata_count), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    @(negedge aud_mclk);
    aud_mrst_n = 1'b1;

    // basic stereo frame; rx_en rises after a right-phase lead-in so the left edge starts framing
    for (int i = 0; i < 3; i++) sclk_cycle(1'b1, 1'b0);
    rx_en = 1'b1;
    exp_q.push_back({3'd0, 32'hA5C3F000});
    exp_q.push_back({3'd1, 32'h0F1E2D00});
    send_slot(1'b0, 24'hA5C3F0);
    send_slot(1'b1, 24'h0F1E2D);
    wait_drain("stereo");
    check("stereo_frame_err", 64'(fe_cnt), 64'd0);

    // truncation: 10 left bits then lrclk toggles
    for (int i = 0; i <= 10; i++) sclk_cycle(1'b0, i[0]);
    exp_q.push_back({3'd1, 32'h12345600});
    send_slot(1'b1, 24'h123456);
    wait_drain("trunc");
    check("trunc_frame_err", 64'(fe_cnt), 64'd1);

    // overflow with tready held low
    @(negedge aud_mclk);
    m_axis_tready = 1'b0;
    send_slot(1'b0, 24'h000001);
    send_slot(1'b1, 24'hFFFFFF);
    send_slot(1'b0, 24'h800000);
    send_slot(1'b1, 24'h7FFFFF);
    settle();
    check("ovf_count4", 64'(fifo_rdata_count), 64'd4);
    check("ovf_irq_before", 64'(irq), 64'd0);
    send_slot(1'b0, 24'hDEAD01);
    settle();
    check("ovf_count_sat", 64'(fifo_rdata_count), 64'd4);
    check("ovf_irq_set", 64'(irq), 64'd1);
    exp_q.push_back({3'd0, 32'h00000100});
    exp_q.push_back({3'd1, 32'hFFFFFF00});
    exp_q.push_back({3'd0, 32'h80000000});
    exp_q.push_back({3'd1, 32'h7FFFFF00});
    @(negedge aud_mclk);
    m_axis_tready = 1'b1;
    wait_drain("ovf");
    check("ovf_count_empty", 64'(fifo_rdata_count), 64'd0);
    check("ovf_irq_sticky", 64'(irq), 64'd1);
    @(negedge aud_mclk);
    irq_clr = 1'b1;
    @(negedge aud_mclk);
    irq_clr = 1'b0;
    #1;
    check("irq_cleared", 64'(irq), 64'd0);

    // backpressure: tready toggles every other cycle during a 3-word burst
    exp_q.push_back({3'd1, 32'h7FFFFE00});
    exp_q.push_back({3'd0, 32'h80000100});
    exp_q.push_back({3'd1, 32'h5A5A5A00});
    bp_done = 1'b0;
    fork
      begin
        send_slot(1'b1, 24'h7FFFFE);
        send_slot(1'b0, 24'h800001);
        send_slot(1'b1, 24'h5A5A5A);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          repeat (2) @(negedge aud_mclk);
          m_axis_tready = ~m_axis_tready;
        end
      end
    join
    @(negedge aud_mclk);
    m_axis_tready = 1'b1;
    wait_drain("bp");

    // async reset during bit 12 of a word with one entry buffered
    @(negedge aud_mclk);
    m_axis_tready = 1'b0;
    send_slot(1'b0, 24'hC0FFEE);
    for (int i = 0; i <= 12; i++) sclk_cycle(1'b1, 1'b1);
    settle();
    check("prerst_count", 64'(fifo_rdata_count), 64'd1);
    check("prerst_tvalid", 64'(m_axis_tvalid), 64'd1);
    @(posedge aud_mclk);
    #2;
    aud_mrst_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_tdata", 64'(m_axis_tdata), 64'd0);
    check("midrst_count", 64'(fifo_rdata_count), 64'd0);
    check("midrst_irq", 64'(irq), 64'd0);
    @(negedge aud_mclk);
    lrclk_in = 1'b0;
    sclk_in = 1'b0;
    repeat (3) @(negedge aud_mclk);
    aud_mrst_n = 1'b1;
    m_axis_tready = 1'b1;
    // no lrclk edge during this slot, so nothing may be taken
    send_slot(1'b0, 24'h654321);
    settle();
    check("postrst_no_word", 64'(fifo_rdata_count), 64'd0);
    exp_q.push_back({3'd1, 32'hABCDEF00});
    send_slot(1'b1, 24'hABCDEF);
    wait_drain("postrst");

    // rx_en low for one lrclk period
    @(negedge aud_mclk);
    rx_en = 1'b0;
    send_slot(1'b0, 24'h111111);
    send_slot(1'b1, 24'h222222);
    settle();
    check("dis_count", 64'(fifo_rdata_count), 64'd0);
    rx_en = 1'b1;
    exp_q.push_back({3'd0, 32'h33333300});
    send_slot(1'b0, 24'h333333);
    wait_drain("reen");
    check("final_frame_err", 64'(fe_cnt), 64'd1);
    check("final_irq", 64'(irq), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
